// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, parity bit, stop bit.
// One bit is sampled per clock; the results are registered on the stop-bit edge.
`timescale 1ns/1ps
module serial_frame_rx #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             perr,
  output logic             ferr,
  output logic             busy,
  output logic [7:0]       frame_cnt
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             par_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      dout      <= '0;
      valid     <= 1'b0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      valid <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      case (state)
        IDLE: begin
          if (!din) begin
            state   <= DATA;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        DATA: begin
          shreg[bit_cnt] <= din;
          bit_cnt        <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(WIDTH - 1)) state <= PARITY;
        end
        PARITY: begin
          par_bit <= din;
          state   <= STOP;
        end
        STOP: begin
          // Always return to IDLE; a low stop bit is never reused as a start bit.
          state <= IDLE;
          busy  <= 1'b0;
          if (din) begin
            dout      <= shreg;
            valid     <= 1'b1;
            perr      <= ((^shreg) ^ par_bit) != ODD_PARITY;
            frame_cnt <= frame_cnt + 8'd1;
          end else begin
            ferr <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames are queued as expected events,
// and a monitor pops and compares them whenever valid or ferr appears.
`timescale 1ns/1ps
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b1;
  logic [7:0] dout;
  logic       valid, perr, ferr, busy;
  logic [7:0] frame_cnt;

  serial_frame_rx #(.WIDTH(8), .ODD_PARITY(1'b0)) dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout), .valid(valid),
    .perr(perr), .ferr(ferr), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_ferr;
    logic [7:0] d;
    bit         p;
    logic [7:0] cnt;
    int         gap;
  } exp_t;

  exp_t       sbq[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_cnt  = '0;
  logic [7:0] exp_dout = '0;
  int         cycle = 0;
  int         last_valid_cyc = -100;
  bit         prev_pulse = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    din = b;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input bit exp_perr, input int gap);
    exp_t e;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    if (stop) begin
      exp_cnt  = exp_cnt + 8'd1;
      exp_dout = d;
      e = '{is_ferr: 1'b0, d: d, p: exp_perr, cnt: exp_cnt, gap: gap};
    end else begin
      e = '{is_ferr: 1'b1, d: exp_dout, p: 1'b0, cnt: exp_cnt, gap: 0};
    end
    sbq.push_back(e);
  endtask

  // Monitor: samples 1 ns after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cycle++;
    if (valid || ferr) begin
      if (prev_pulse) chk("pulse_two_cycles", 32'd1, 32'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_event", {valid, ferr}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("ev_ferr",  ferr,      e.is_ferr);
        chk("ev_valid", valid,     !e.is_ferr);
        chk("ev_dout",  dout,      e.d);
        chk("ev_perr",  perr,      e.p);
        chk("ev_cnt",   frame_cnt, e.cnt);
        chk("ev_busy",  busy,      32'd0);
        if (e.gap != 0) chk("ev_gap", cycle - last_valid_cyc, e.gap);
      end
      if (valid) last_valid_cyc = cycle;
    end else if (perr) begin
      chk("perr_without_valid", perr, 32'd0);
    end
    prev_pulse = valid | ferr;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    chk("rst_dout",  dout,      32'd0);
    chk("rst_valid", valid,     32'd0);
    chk("rst_perr",  perr,      32'd0);
    chk("rst_ferr",  ferr,      32'd0);
    chk("rst_busy",  busy,      32'd0);
    chk("rst_cnt",   frame_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_bit(1'b1);

    // Good frame, then the same frame with wrong parity
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 0);
    send_bit(1'b1);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 0);
    send_bit(1'b1);
    // Bad stop bit; the low stop must not start a frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(posedge clk); #2;
    chk("idle_after_ferr_busy", busy, 32'd0);
    // Back-to-back frames, 11 clocks apart
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 0);
    send_frame(8'hFE, 1'b1, 1'b1, 1'b0, 11);
    send_bit(1'b1);
    send_bit(1'b1);

    // Asynchronous reset mid-frame after the 4th data bit
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    @(posedge clk); #1;
    chk("midframe_busy", busy, 32'd1);
    #2;
    rst = 1'b1;
    din = 1'b1;
    #1;
    chk("arst_dout",  dout,      32'd0);
    chk("arst_busy",  busy,      32'd0);
    chk("arst_cnt",   frame_cnt, 32'd0);
    chk("arst_valid", valid,     32'd0);
    #2;
    rst = 1'b0;
    exp_cnt  = '0;
    exp_dout = '0;
    send_bit(1'b1);
    send_bit(1'b1);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 0);
    send_bit(1'b1);

    // 256 good frames: alternate idle gaps and back-to-back
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_cnt  = '0;
    exp_dout = '0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] d;
      d = 8'(i * 37 + 11);
      send_frame(d, ^d, 1'b1, 1'b0, 0);
      if (i[0] == 1'b0) begin
        send_bit(1'b1);
        @(posedge clk); #2;
        chk("gap_busy", busy, 32'd0);
      end
    end
    send_bit(1'b1);
    send_bit(1'b1);
    chk("wrap_cnt", frame_cnt, 32'd0);

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
    #2;
    chk("sb_drain", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
